// File: rtl/clk_div_rst_gen.sv
// Clock/reset generator: synchronised, stretched reset plus NUM_CH glitch-free reloadable clock dividers.
// Optional CLKDIV_ODD_DUTY_EN adds a falling-edge flop per channel for 50% duty on odd divisors.
module clk_div_rst_gen #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned DEFAULT_DIV  = 2,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned RESET_CYCLES = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CH*DIV_W-1:0] i_div,
    input  logic [NUM_CH-1:0]       i_load,
    output logic                    o_rst_n,
    output logic [NUM_CH-1:0]       o_clk,
    output logic [NUM_CH-1:0]       o_tick,
    output logic [NUM_CH-1:0]       o_busy
);

    localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {S_RST, S_SYNC, S_HOLD, S_RUN} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   run_c;
    logic                   rst_n_nxt;

    // Reset-release synchroniser: shifts ones in from the first edge after i_rst_n rises
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Hold counter reads 1 in the first S_HOLD cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_cnt <= HOLD_W'(1);
        end else if (state != S_HOLD) begin
            hold_cnt <= HOLD_W'(1);
        end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:  state_nxt = S_SYNC;
            S_SYNC: begin
                if (sync_q[SYNC_STAGES-1]) begin
                    state_nxt = (RESET_CYCLES == 1) ? S_RUN : S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN:  state_nxt = S_RUN;
            default: state_nxt = S_RST;
        endcase
    end

    always_comb begin
        run_c     = (state == S_RUN);
        rst_n_nxt = (state_nxt == S_RUN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rst_n <= 1'b0;
        end else begin
            o_rst_n <= rst_n_nxt;
        end
    end

    // Per-channel divider state; pos_q is the position emitted at the next edge
    logic [DIV_W-1:0]  act_q  [NUM_CH];
    logic [DIV_W-1:0]  act_d  [NUM_CH];
    logic [DIV_W-1:0]  pend_q [NUM_CH];
    logic [DIV_W-1:0]  pend_d [NUM_CH];
    logic [DIV_W-1:0]  pos_q  [NUM_CH];
    logic [DIV_W-1:0]  pos_d  [NUM_CH];
    logic [NUM_CH-1:0] clk_q;
    logic [NUM_CH-1:0] clk_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] busy_q;
    logic [NUM_CH-1:0] busy_d;

    always_comb begin : ch_next
        logic [DIV_W-1:0] ld;
        logic [DIV_W-1:0] ncur;
        for (int k = 0; k < NUM_CH; k++) begin
            act_d[k]  = act_q[k];
            pend_d[k] = pend_q[k];
            pos_d[k]  = pos_q[k];
            clk_d[k]  = 1'b0;
            tick_d[k] = 1'b0;
            busy_d[k] = busy_q[k];
            ld        = i_div[k*DIV_W +: DIV_W];
            if (ld < DIV_W'(2)) begin
                ld = DIV_W'(2);
            end
            ncur = i_load[k] ? ld : (busy_q[k] ? pend_q[k] : act_q[k]);
            if (!run_c) begin
                act_d[k]  = i_load[k] ? ld : act_q[k];
                pend_d[k] = act_d[k];
                pos_d[k]  = '0;
                busy_d[k] = 1'b0;
            end else if (pos_q[k] == '0) begin
                // Wrap edge: a same-cycle load beats the pending value
                act_d[k]  = ncur;
                pend_d[k] = ncur;
                busy_d[k] = 1'b0;
                tick_d[k] = 1'b1;
                clk_d[k]  = 1'b1;
                pos_d[k]  = DIV_W'(1);
            end else begin
                if (i_load[k]) begin
                    pend_d[k] = ld;
                    busy_d[k] = 1'b1;
                end
                clk_d[k] = (pos_q[k] < (act_q[k] >> 1));
                pos_d[k] = (pos_q[k] == act_q[k] - DIV_W'(1)) ? '0 : pos_q[k] + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                act_q[k]  <= DIV_W'(DEFAULT_DIV);
                pend_q[k] <= DIV_W'(DEFAULT_DIV);
                pos_q[k]  <= '0;
            end
            clk_q  <= '0;
            tick_q <= '0;
            busy_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                act_q[k]  <= act_d[k];
                pend_q[k] <= pend_d[k];
                pos_q[k]  <= pos_d[k];
            end
            clk_q  <= clk_d;
            tick_q <= tick_d;
            busy_q <= busy_d;
        end
    end

    assign o_tick = tick_q;
    assign o_busy = busy_q;

`ifdef CLKDIV_ODD_DUTY_EN
    logic [NUM_CH-1:0] neg_q;
    logic [NUM_CH-1:0] odd_c;

    // Half-cycle extension of the high phase, only for odd active divisors
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            neg_q <= '0;
        end else begin
            neg_q <= clk_q;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            odd_c[k] = act_q[k][0];
        end
    end

    assign o_clk = clk_q | (neg_q & odd_c);
`else
    assign o_clk = clk_q;
`endif

endmodule

// File: doc/clk_div_rst_gen.md
# clk_div_rst_gen

Parametrised clock/reset generation block for the clkdiv design: takes the single source clock and raw asynchronous reset and produces a synchronised, stretched reset plus NUM_CH independently programmable divided clocks. Each channel also provides a one-cycle tick in the source domain. Sits at the top of the clkdiv hierarchy and feeds every downstream divided-clock consumer. Divisors are runtime-reloadable without glitches.

## Interface
- NUM_CH, 2, number of divider channels (1..8)
- DIV_W, 8, divisor/counter width per channel
- DEFAULT_DIV, 2, divisor loaded into every channel by reset (2..2^DIV_W-1)
- SYNC_STAGES, 2, reset-release synchroniser depth (>=2)
- RESET_CYCLES, 10, extra i_clk cycles o_rst_n is held low after synchronisation (>=1)

- i_clk  in  1  source clock; all logic on its rising edge (falling edge only with the Configuration macro)
- i_rst_n  in  1  asynchronous, active-low reset
- i_div  in  NUM_CH*DIV_W  requested divisor; channel k at [k*DIV_W +: DIV_W]
- i_load  in  NUM_CH  per-channel load strobe, sampled on i_clk
- o_rst_n  out  1  synchronised, stretched reset, active low
- o_clk  out  NUM_CH  divided clocks
- o_tick  out  NUM_CH  one-cycle pulse in the cycle each o_clk rises
- o_busy  out  NUM_CH  divisor load pending

## Operation
- Reset (i_rst_n=0, async): o_rst_n=0, o_clk=0, o_tick=0, o_busy=0, all counters 0, active and pending divisors = DEFAULT_DIV, sequencer in S_RST.
- Sequencer FSM: S_RST -> S_SYNC once i_rst_n is high; S_SYNC shifts 1 through SYNC_STAGES flops -> S_HOLD when the last stage is 1; S_HOLD counts RESET_CYCLES -> S_RUN; S_RUN drives o_rst_n=1. Deassertion is synchronous, assertion async.
- Channels idle (cnt=0, o_clk=0, o_tick=0) until S_RUN.
- In S_RUN, per channel with active divisor N: cnt increments each cycle, wraps from N-1 to 0. o_clk=1 while cnt < floor(N/2), else 0. o_tick=1 when cnt=0.
- Divisor clamp: captured values 0 or 1 are stored as 2.
- Load: i_load[k]=1 captures i_div slice into pending, o_busy[k]=1. Pending becomes active on the wrap (cnt N-1 -> 0), o_busy clears the same edge. Reload is glitch-free: the current period always completes.
- Load while busy: pending overwritten, last value wins.
- Load in the wrap cycle: the new value bypasses pending and is active from that wrap. o_busy stays 0.
- Load while not in S_RUN: written directly to active, o_busy stays 0.
- i_rst_n low mid-operation: immediate return to reset state. Pending loads are discarded.

## Timing
- Edge 1 is the first i_clk rising edge at which i_rst_n=1. o_rst_n rises after edge SYNC_STAGES+RESET_CYCLES (defaults: edge 12).
- First o_tick/o_clk high in the cycle following o_rst_n rising.
- o_clk, o_tick, o_busy, o_rst_n are registered. o_clk may be combined per Configuration.
- Period of o_clk = N i_clk cycles. Without the macro, high for floor(N/2) cycles and low for ceil(N/2) cycles.

## Configuration
- CLKDIV_ODD_DUTY_EN defined: each channel adds a falling-edge flop sampling its rising-edge o_clk term. o_clk = posedge term OR negedge term, so odd N gives exactly N/2 cycles high (50% duty). Even N uses the posedge term only. o_tick is unchanged.
- Undefined: no falling-edge logic. Odd N gives floor(N/2)-cycle high pulse.

## Test plan
- Reset release, defaults: deassert i_rst_n -> o_rst_n rises after edge 12; o_clk[0] toggles with period 2, o_tick every 2 cycles.
- Load i_div[0]=6 mid-period, N=2 active -> o_busy[0]=1 until the wrap; next period is 6 cycles, 3 high/3 low; no short pulse.
- i_div[1]=5, macro undefined -> 2 high/3 low. With CLKDIV_ODD_DUTY_EN -> 2.5 cycles high, period 5.
- Load 0 and 1 -> both behave as N=2. Two loads (7 then 4) before the wrap -> 4 is applied.
- Load coincident with the wrap cycle (N=3 -> 8) -> next period is 8, o_busy never asserts.
- i_rst_n pulsed low mid-period with a load pending -> all outputs 0 immediately; after release, N=DEFAULT_DIV and o_rst_n timing repeats.
